// File: rtl/alu_ctrl.sv
// alu_ctrl -- sequencing controller in front of a shared combinational ALU.
//
// Accepts one request at a time (valid/ready), drives the registered operands
// and op select to the external ALU, and returns the result on a valid/ready
// response channel. Shifts (sll/srl/sra) are done iteratively, one bit per
// cycle, in a local working register unless ALU_CTRL_FAST_SHIFT_EN is
// defined, in which case a local 32-bit barrel shifter finishes them in the
// single EXEC cycle. Op codes 1010-1111 are illegal and return data 0 with
// rsp_err set, at ALU-op latency.
//
// Ports
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_opA, req_opB, req_sel  request operands and op code
//   alu_opA, alu_opB, alu_sel  registered request driven to the ALU
//   alu_result                 ALU combinational result
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_err          result and illegal-op flag
//   busy                       controller not in IDLE
//
// Config macro: ALU_CTRL_FAST_SHIFT_EN (undefined = iterative shifts).

module alu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_opA,
    input  logic [31:0] req_opB,
    input  logic [3:0]  req_sel,
    output logic [31:0] alu_opA,
    output logic [31:0] alu_opB,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;

    state_t state;

    function automatic logic is_shift(input logic [3:0] sel);
        return (sel == OP_SLL) || (sel == OP_SRL) || (sel == OP_SRA);
    endfunction

    function automatic logic is_illegal(input logic [3:0] sel);
        return sel[3] & (sel[2] | sel[1]);   // 1010..1111
    endfunction

    // Handshake/status outputs are decoded straight from the state register.
    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

`ifdef ALU_CTRL_FAST_SHIFT_EN
    // Barrel shifter for the single-cycle shift path; only opB[4:0] counts.
    logic [31:0] fast_res;

    always_comb begin
        fast_res = '0;
        case (alu_sel)
            OP_SLL:  fast_res = alu_opA << alu_opB[4:0];
            OP_SRL:  fast_res = alu_opA >> alu_opB[4:0];
            OP_SRA:  fast_res = $unsigned($signed(alu_opA) >>> alu_opB[4:0]);
            default: fast_res = '0;
        endcase
    end
`else
    logic [31:0] work;   // value being shifted one bit per cycle
    logic [4:0]  cnt;    // remaining shift steps
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            alu_opA  <= '0;
            alu_opB  <= '0;
            alu_sel  <= '0;
`ifndef ALU_CTRL_FAST_SHIFT_EN
            work     <= '0;
            cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is just (state == IDLE) here since rst is low.
                    if (req_valid) begin
                        alu_opA <= req_opA;
                        alu_opB <= req_opB;
                        alu_sel <= req_sel;
`ifdef ALU_CTRL_FAST_SHIFT_EN
                        state   <= EXEC;
`else
                        if (is_shift(req_sel)) begin
                            work  <= req_opA;
                            cnt   <= req_opB[4:0];
                            state <= SHIFT;
                        end else begin
                            state <= EXEC;
                        end
`endif
                    end
                end

                EXEC: begin
                    if (is_illegal(alu_sel)) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
`ifdef ALU_CTRL_FAST_SHIFT_EN
                        rsp_data <= is_shift(alu_sel) ? fast_res : alu_result;
`else
                        rsp_data <= alu_result;
`endif
                        rsp_err  <= 1'b0;
                    end
                    state <= DONE;
                end

`ifndef ALU_CTRL_FAST_SHIFT_EN
                SHIFT: begin
                    if (cnt == 5'd0) begin
                        rsp_data <= work;
                        rsp_err  <= 1'b0;
                        state    <= DONE;
                    end else begin
                        case (alu_sel)
                            OP_SLL:  work <= {work[30:0], 1'b0};
                            OP_SRL:  work <= {1'b0, work[31:1]};
                            default: work <= {work[31], work[31:1]};   // sra
                        endcase
                        cnt <= cnt - 5'd1;
                    end
                end
`endif

                DONE: begin
                    // rsp_data/rsp_err are untouched here, so they hold under back-pressure.
                    if (rsp_ready) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits and the op select at 4 bits.
REQ-002 The block SHALL have these ports, one per line (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous, active-high reset
  req_valid  in  1  request offered
  req_ready  out  1  controller can accept a request
  req_opA  in  32  operand A
  req_opB  in  32  operand B
  req_sel  in  4  op code (0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra)
  alu_opA  out  32  operand A to the shared combinational ALU
  alu_opB  out  32  operand B to the shared combinational ALU
  alu_sel  out  4  op select to the ALU
  alu_result  in  32  ALU combinational result
  rsp_valid  out  1  result available
  rsp_ready  in  1  consumer accepts result
  rsp_data  out  32  result
  rsp_err  out  1  request carried an illegal op code
  busy  out  1  state is not IDLE

Function
REQ-003 The FSM SHALL have states IDLE, EXEC, SHIFT and DONE.
REQ-004 req_ready SHALL be 1 only in IDLE with rst low; acceptance is req_valid & req_ready at a rising edge.
REQ-005 On acceptance the block SHALL register opA, opB and sel internally; req_* values presented at any other time SHALL be ignored.
REQ-006 Codes 0000-0110 and 1010-1111 SHALL go IDLE->EXEC; codes 0111-1001 SHALL go IDLE->SHIFT, loading the shift counter with opB[4:0].
REQ-007 alu_opA, alu_opB and alu_sel SHALL always reflect the registered request and SHALL be stable throughout EXEC.
REQ-008 In EXEC the block SHALL capture alu_result into rsp_data, set rsp_err=0 and go to DONE.
REQ-009 For codes 1010-1111, EXEC SHALL capture rsp_data=0 and set rsp_err=1, with the same latency as a legal ALU op.
REQ-010 In SHIFT with counter 0, the block SHALL go to DONE with rsp_data equal to the working value.
REQ-011 In SHIFT with counter nonzero, each cycle the block SHALL shift the working value by one bit and decrement the counter:
  0111: left, zero fill
  1000: right, zero fill
  1001: right, sign bit replicated
REQ-012 Only opB[4:0] SHALL set the shift amount; opB[31:5] SHALL be ignored.
REQ-013 rsp_valid SHALL be 1 exactly while the state is DONE.
REQ-014 rsp_data and rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-015 DONE SHALL go to IDLE on rsp_valid & rsp_ready; no request SHALL be accepted in that same cycle.
REQ-016 Latency SHALL be:
  - ALU op, accepted at edge N: rsp_valid first high after edge N+2.
  - Iterative shift by k: rsp_valid first high after edge N+2+k.
REQ-017 busy SHALL equal (state != IDLE).

Reset
REQ-018 While rst=1 at a rising edge, state SHALL become IDLE and rsp_valid, rsp_err, rsp_data, alu_opA, alu_opB, alu_sel, busy and the shift counter SHALL become 0.
REQ-019 req_ready SHALL be 0 while rst=1.
REQ-020 Reset asserted in any state, including mid-SHIFT or DONE with rsp_ready=0, SHALL abort the operation and discard its result, with no rsp_valid afterwards.

Configuration
REQ-021 With macro ALU_CTRL_FAST_SHIFT_EN defined:
  - Codes 0111-1001 SHALL go IDLE->EXEC and complete in one EXEC cycle using a 32-bit barrel shifter by opB[4:0].
  - Latency SHALL be as for ALU ops, and the SHIFT state SHALL be unreachable.
REQ-022 Without ALU_CTRL_FAST_SHIFT_EN, shifts SHALL use the iterative SHIFT path of REQ-011.

Verification
REQ-023 Add:
  - Stimulus: sel=0000, opA=5, opB=7, rsp_ready=1.
  - Response: rsp_data=12, rsp_err=0, rsp_valid high after edge N+2, then req_ready=1 one cycle later.
REQ-024 SRA:
  - Stimulus: sel=1001, opA=0x80000010, opB=0x24 (amount 4), no macro.
  - Response: rsp_data=0xF8000001, rsp_valid after edge N+6.
  - With ALU_CTRL_FAST_SHIFT_EN: same data, rsp_valid after edge N+2.
REQ-025 Back-pressure:
  - Stimulus: sel=0001, opA=3, opB=5, rsp_ready=0 for 10 cycles.
  - Response: rsp_valid and rsp_data=0xFFFFFFFE held stable; req_ready=0 throughout; a new req_valid is ignored.
REQ-026 Illegal op:
  - Stimulus: sel=1100.
  - Response: rsp_data=0, rsp_err=1, rsp_valid after edge N+2.
REQ-027 Mid-shift reset:
  - Stimulus: sel=0111, opA=1, opB=31; rst pulsed for 1 cycle after 5 shift cycles.
  - Response: all outputs 0, no rsp_valid, req_ready=1 the cycle after rst deasserts.
